// File: rtl/dlsc_pcie_s6_inbound_write.sv
// dlsc_pcie_s6_inbound_write: replays inbound PCIe memory write TLPs as aligned AXI write bursts.
// Optional DLSC_PCIE_S6_INBOUND_WRITE_ZERO_LEN_EN drops zero-length writes instead of issuing them.
module dlsc_pcie_s6_inbound_write #(
    parameter int ADDR = 32,
    parameter int LEN  = 4,
    parameter int MOT  = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            tlp_h_ready,
    input  logic            tlp_h_valid,
    input  logic [ADDR-3:0] tlp_h_addr,
    input  logic [9:0]      tlp_h_len,
    input  logic [3:0]      tlp_h_be_first,
    input  logic [3:0]      tlp_h_be_last,
    output logic            tlp_d_ready,
    input  logic            tlp_d_valid,
    input  logic [31:0]     tlp_d_data,
    input  logic            axi_aw_ready,
    output logic            axi_aw_valid,
    output logic [ADDR-1:0] axi_aw_addr,
    output logic [LEN-1:0]  axi_aw_len,
    input  logic            axi_w_ready,
    output logic            axi_w_valid,
    output logic            axi_w_last,
    output logic [3:0]      axi_w_strb,
    output logic [31:0]     axi_w_data,
    output logic            axi_b_ready,
    input  logic            axi_b_valid,
    input  logic [1:0]      axi_b_resp,
    output logic            wr_busy,
    output logic            wr_err
);
    localparam int OW = $clog2(MOT + 1);

    typedef enum logic [1:0] {ST_IDLE, ST_AW, ST_W} state_t;

    state_t          state, state_nx;
    logic            rdy;
    logic [ADDR-3:0] addr;
    logic [10:0]     remaining;
    logic [3:0]      be_first, be_last;
    logic            first;
    logic [LEN:0]    beats;
    logic [OW-1:0]   outstanding;
    logic [10:0]     space, burst;
    logic            zero, zl_hdr;
    logic            h_hs, aw_hs, d_hs, b_hs, w_end, tlp_end;

`ifdef DLSC_PCIE_S6_INBOUND_WRITE_ZERO_LEN_EN
    logic zero_r;
    assign zero   = zero_r;
    assign zl_hdr = (tlp_h_len == 10'd1) && (tlp_h_be_first == 4'h0);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) zero_r <= 1'b0;
        else if (h_hs) zero_r <= zl_hdr;
    end
`else
    assign zero   = 1'b0;
    assign zl_hdr = 1'b0;
`endif

    // bursts stop at the next 2^LEN-DWORD boundary
    assign space   = 11'(2 ** LEN) - 11'(addr[LEN-1:0]);
    assign burst   = (remaining < space) ? remaining : space;
    assign h_hs    = tlp_h_valid & tlp_h_ready;
    assign aw_hs   = axi_aw_valid & axi_aw_ready;
    assign d_hs    = tlp_d_valid & tlp_d_ready;
    assign b_hs    = axi_b_valid & axi_b_ready;
    assign w_end   = d_hs & ((beats == (LEN+1)'(1)) | zero);
    assign tlp_end = remaining == burst;

    assign axi_aw_addr = {addr, 2'b00};
    assign axi_aw_len  = LEN'(burst - 11'd1);
    assign axi_w_data  = tlp_d_data;
    assign axi_w_last  = beats == (LEN+1)'(1);
    assign axi_w_strb  = first ? be_first : (axi_w_last && tlp_end) ? be_last : 4'hF;
    assign axi_b_ready = rdy;
    assign wr_busy     = (state != ST_IDLE) || (outstanding != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else state <= state_nx;
    end

    always_comb begin
        state_nx     = state;
        tlp_h_ready  = 1'b0;
        tlp_d_ready  = 1'b0;
        axi_aw_valid = 1'b0;
        axi_w_valid  = 1'b0;
        case (state)
            ST_IDLE: begin
                tlp_h_ready = rdy;
                if (tlp_h_valid && rdy) state_nx = zl_hdr ? ST_W : ST_AW;
            end
            ST_AW: begin
                axi_aw_valid = outstanding < OW'(MOT);
                if (axi_aw_valid && axi_aw_ready) state_nx = ST_W;
            end
            ST_W: begin
                tlp_d_ready = axi_w_ready | zero;
                axi_w_valid = tlp_d_valid & ~zero;
                if (w_end) state_nx = (tlp_end || zero) ? ST_IDLE : ST_AW;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdy         <= 1'b0;
            addr        <= '0;
            remaining   <= '0;
            be_first    <= '0;
            be_last     <= '0;
            first       <= 1'b0;
            beats       <= '0;
            outstanding <= '0;
            wr_err      <= 1'b0;
        end else begin
            rdy <= 1'b1;
            if (h_hs) begin
                addr      <= tlp_h_addr;
                remaining <= {tlp_h_len == 10'd0, tlp_h_len};
                be_first  <= tlp_h_be_first;
                be_last   <= tlp_h_be_last;
                first     <= 1'b1;
            end
            if (aw_hs) beats <= (LEN+1)'(burst);
            if (d_hs) begin
                first <= 1'b0;
                beats <= beats - (LEN+1)'(1);
            end
            if (w_end) begin
                addr      <= addr + (ADDR-2)'(burst);
                remaining <= remaining - burst;
            end
            if (aw_hs != b_hs) outstanding <= aw_hs ? outstanding + OW'(1) : outstanding - OW'(1);
            if (b_hs && axi_b_resp != 2'b00) wr_err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_dlsc_pcie_s6_inbound_write.sv
// tb_dlsc_pcie_s6_inbound_write: random TLP traffic against a queue-based model of AXI burst splitting.
module tb_dlsc_pcie_s6_inbound_write;
    localparam int LEN = 4;
    localparam int MOT = 2;

    logic        clk, rst_n;
    logic        tlp_h_ready, tlp_h_valid;
    logic [29:0] tlp_h_addr;
    logic [9:0]  tlp_h_len;
    logic [3:0]  tlp_h_be_first, tlp_h_be_last;
    logic        tlp_d_ready, tlp_d_valid;
    logic [31:0] tlp_d_data;
    logic        axi_aw_ready, axi_aw_valid;
    logic [31:0] axi_aw_addr;
    logic [LEN-1:0] axi_aw_len;
    logic        axi_w_ready, axi_w_valid, axi_w_last;
    logic [3:0]  axi_w_strb;
    logic [31:0] axi_w_data;
    logic        axi_b_ready, axi_b_valid;
    logic [1:0]  axi_b_resp;
    logic        wr_busy, wr_err;

    dlsc_pcie_s6_inbound_write #(.ADDR(32), .LEN(LEN), .MOT(MOT)) dut (
        .clk(clk), .rst_n(rst_n),
        .tlp_h_ready(tlp_h_ready), .tlp_h_valid(tlp_h_valid), .tlp_h_addr(tlp_h_addr),
        .tlp_h_len(tlp_h_len), .tlp_h_be_first(tlp_h_be_first), .tlp_h_be_last(tlp_h_be_last),
        .tlp_d_ready(tlp_d_ready), .tlp_d_valid(tlp_d_valid), .tlp_d_data(tlp_d_data),
        .axi_aw_ready(axi_aw_ready), .axi_aw_valid(axi_aw_valid), .axi_aw_addr(axi_aw_addr),
        .axi_aw_len(axi_aw_len), .axi_w_ready(axi_w_ready), .axi_w_valid(axi_w_valid),
        .axi_w_last(axi_w_last), .axi_w_strb(axi_w_strb), .axi_w_data(axi_w_data),
        .axi_b_ready(axi_b_ready), .axi_b_valid(axi_b_valid), .axi_b_resp(axi_b_resp),
        .wr_busy(wr_busy), .wr_err(wr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {logic [31:0] a; logic [3:0] l;} aw_t;
    typedef struct packed {logic [31:0] d; logic [3:0] s; logic l;} w_t;

    aw_t exp_aw[$];
    w_t exp_w[$];
    logic [31:0] pay_q[$];
    int checks = 0, failures = 0;
    int mo = 0, pend = 0, aw_cnt = 0, b_used = 0, b_grant = 0, err_req = 0, err_done = 0;
    bit b_hold = 0, fast = 1, d_hs = 0, aw_stall = 0;
    logic [35:0] st_aw;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        failures++;
        $display("FAIL %s timed out", name);
    endtask

    // reference: split the TLP at 2^LEN-DWORD boundaries, strobes by TLP beat position
    task automatic model(input logic [29:0] a, input logic [9:0] n, input logic [3:0] bf, input logic [3:0] bl);
        int len, rem, i, b;
        aw_t ea;
        w_t ew;
        len = (n == 0) ? 1024 : int'(n);
        rem = len;
        i = 0;
`ifdef DLSC_PCIE_S6_INBOUND_WRITE_ZERO_LEN_EN
        if (len == 1 && bf == 4'h0) begin
            pay_q.push_back($urandom);
            return;
        end
`endif
        while (rem > 0) begin
            b = (1 << LEN) - int'(a[LEN-1:0]);
            if (b > rem) b = rem;
            ea.a = {a, 2'b00};
            ea.l = 4'(b - 1);
            exp_aw.push_back(ea);
            for (int j = 0; j < b; j++) begin
                ew.d = $urandom;
                ew.s = (i == 0) ? bf : (i == len - 1) ? bl : 4'hF;
                ew.l = (j == b - 1);
                pay_q.push_back(ew.d);
                exp_w.push_back(ew);
                i++;
            end
            a = a + 30'(b);
            rem = rem - b;
        end
    endtask

    task automatic send(input logic [29:0] a, input logic [9:0] n, input logic [3:0] bf, input logic [3:0] bl);
        int k;
        model(a, n, bf, bl);
        @(posedge clk);
        #1;
        tlp_h_valid = 1'b1;
        tlp_h_addr = a;
        tlp_h_len = n;
        tlp_h_be_first = bf;
        tlp_h_be_last = bl;
        k = 0;
        forever begin
            @(negedge clk);
            if (tlp_h_ready) break;
            if (++k > 5000) begin
                fail_now("header_accept");
                break;
            end
        end
        @(posedge clk);
        #1;
        tlp_h_valid = 1'b0;
    endtask

    task automatic drain(input int budget);
        int k;
        k = 0;
        forever begin
            @(negedge clk);
            if (exp_aw.size() == 0 && exp_w.size() == 0 && pay_q.size() == 0 && pend == 0 && !wr_busy) break;
            if (++k > budget) begin
                fail_now("drain");
                break;
            end
        end
    endtask

    // monitor: every AXI handshake pops the scoreboard
    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            aw_stall = 0;
            d_hs = 0;
        end else begin
            if (mo == MOT) chk("aw_withheld", axi_aw_valid, 0);
            if (aw_stall) chk("aw_stable", {axi_aw_valid, axi_aw_addr, axi_aw_len}, {1'b1, st_aw});
            aw_stall = axi_aw_valid && !axi_aw_ready;
            st_aw = {axi_aw_addr, axi_aw_len};
            if (axi_aw_valid && axi_aw_ready) begin
                if (exp_aw.size() == 0) fail_now("aw_unexpected");
                else chk("aw", {axi_aw_addr, axi_aw_len}, exp_aw.pop_front());
                mo++;
                pend++;
                aw_cnt++;
            end
            if (axi_w_valid && axi_w_ready) begin
                if (exp_w.size() == 0) fail_now("w_unexpected");
                else chk("w", {axi_w_data, axi_w_strb, axi_w_last}, exp_w.pop_front());
            end
            if (axi_b_valid && axi_b_ready) begin
                mo--;
                pend--;
                b_used++;
                if (axi_b_resp != 2'b00) err_done++;
            end
            d_hs = tlp_d_valid && tlp_d_ready;
        end
    end

    // payload source, AXI slave readies and B responder
    initial forever begin
        @(posedge clk);
        #1;
        if (!rst_n) begin
            tlp_d_valid = 1'b0;
            tlp_d_data = '0;
            axi_aw_ready = 1'b0;
            axi_w_ready = 1'b0;
            axi_b_valid = 1'b0;
            axi_b_resp = 2'b00;
        end else begin
            axi_aw_ready = fast || ($urandom % 3 != 0);
            axi_w_ready = fast || ($urandom % 3 != 0);
            if (d_hs && pay_q.size() > 0) void'(pay_q.pop_front());
            tlp_d_valid = (pay_q.size() > 0) && ((tlp_d_valid && !d_hs) || fast || ($urandom % 4 != 0));
            tlp_d_data = (pay_q.size() > 0) ? pay_q[0] : 32'h0;
            axi_b_valid = (pend > 0) && (!b_hold || b_used < b_grant) && (fast || ($urandom % 2 == 0));
            axi_b_resp = (err_done < err_req) ? 2'b10 : 2'b00;
        end
    end

    initial begin
        int base, k;
        rst_n = 1'b0;
        tlp_h_valid = 1'b0;
        tlp_h_addr = '0;
        tlp_h_len = '0;
        tlp_h_be_first = '0;
        tlp_h_be_last = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_h_ready", tlp_h_ready, 0);
        chk("rst_d_ready", tlp_d_ready, 0);
        chk("rst_aw_valid", axi_aw_valid, 0);
        chk("rst_w_valid", axi_w_valid, 0);
        chk("rst_b_ready", axi_b_ready, 0);
        chk("rst_busy", wr_busy, 0);
        chk("rst_err", wr_err, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("h_ready_rise", tlp_h_ready, 1);
        chk("b_ready_rise", axi_b_ready, 1);

        send(30'h400, 10'd1, 4'hC, 4'h0);
        @(negedge clk);
        chk("busy_after_hdr", wr_busy, 1);
        drain(2000);
        chk("busy_after_b", wr_busy, 0);

        send(30'h40E, 10'd20, 4'hE, 4'h3);
        drain(2000);

        send(30'h800, 10'd0, 4'hF, 4'hF);
        drain(20000);
        chk("err_clear", wr_err, 0);

        b_hold = 1;
        base = aw_cnt;
        send(30'hC00, 10'd48, 4'hF, 4'hF);
        repeat (80) @(negedge clk);
        chk("mot_aw_count", 64'(aw_cnt - base), 2);
        chk("mot_aw_held", axi_aw_valid, 0);
        b_grant = b_used + 1;
        k = 0;
        forever begin
            @(negedge clk);
            if (axi_b_valid) break;
            if (++k > 100) begin
                fail_now("mot_b_release");
                break;
            end
        end
        @(negedge clk);
        chk("mot_aw_after_b", axi_aw_valid, 1);
        b_hold = 0;
        drain(2000);

        err_req = err_done + 1;
        send(30'($urandom), 10'd4, 4'hF, 4'hF);
        drain(2000);
        chk("err_set", wr_err, 1);

        send(30'h123, 10'd1, 4'h0, 4'h5);
        send(30'h200, 10'd3, 4'h7, 4'h1);
        drain(2000);

        fast = 0;
        for (int t = 0; t < 25; t++) begin
            send(30'($urandom), 10'($urandom_range(1, 40)), 4'($urandom), 4'($urandom));
            if (t % 5 == 4) drain(20000);
        end
        drain(20000);
        chk("err_sticky", wr_err, 1);

        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("err_reset", wr_err, 0);
        chk("h_ready_reset", tlp_h_ready, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        send(30'h3F0, 10'd17, 4'h8, 4'hF);
        drain(2000);
        chk("err_after_reset", wr_err, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
